// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 datapath widths and word type
package lc3_pkg;
  localparam int WORD_W = 16;
  localparam int MUX8_SEL_W = 3;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mux8_comb.sv
// mux8_comb: combinational 8-way word selector
module mux8_comb
  import lc3_pkg::*;
(
  input  logic [MUX8_SEL_W-1:0] select,
  input  word_t                 in_0,
  input  word_t                 in_1,
  input  word_t                 in_2,
  input  word_t                 in_3,
  input  word_t                 in_4,
  input  word_t                 in_5,
  input  word_t                 in_6,
  input  word_t                 in_7,
  output word_t                 word
);
  word_t words [8];
  assign words = '{in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7};
  assign word = words[select];
endmodule

// File: rtl/mux_16x8_to_16.sv
// mux_16x8_to_16: registered 8-way 16-bit word selector with sync active-low reset
module mux_16x8_to_16
  import lc3_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MUX8_SEL_W-1:0] select,
  input  logic [WORD_W-1:0]     in_0,
  input  logic [WORD_W-1:0]     in_1,
  input  logic [WORD_W-1:0]     in_2,
  input  logic [WORD_W-1:0]     in_3,
  input  logic [WORD_W-1:0]     in_4,
  input  logic [WORD_W-1:0]     in_5,
  input  logic [WORD_W-1:0]     in_6,
  input  logic [WORD_W-1:0]     in_7,
  output logic [WORD_W-1:0]     out
);
  word_t sel_word;
  mux8_comb u_mux (
    .select(select),
    .in_0(in_0),
    .in_1(in_1),
    .in_2(in_2),
    .in_3(in_3),
    .in_4(in_4),
    .in_5(in_5),
    .in_6(in_6),
    .in_7(in_7),
    .word(sel_word)
  );
  always_ff @(posedge clk)
    out <= !rst_n ? '0 : sel_word;
endmodule

// File: tb/tb_mux_16x8_to_16.sv
// tb_mux_16x8_to_16: directed and randomized checks of the registered 8-way selector
module tb_mux_16x8_to_16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  select = '0;
  logic [15:0] din [8];
  logic [15:0] out;
  int checks = 0;
  int failures = 0;
  mux_16x8_to_16 dut (
    .clk(clk),
    .rst_n(rst_n),
    .select(select),
    .in_0(din[0]),
    .in_1(din[1]),
    .in_2(din[2]),
    .in_3(din[3]),
    .in_4(din[4]),
    .in_5(din[5]),
    .in_6(din[6]),
    .in_7(din[7]),
    .out(out)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_base();
    for (int i = 0; i < 8; i++) din[i] = 16'(15 + i);
  endtask
  task automatic test_reset();
    load_base();
    select = 3'd5;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out !== 16'h0000) begin
        failures++;
        $display("FAIL reset_edge%0d got=%h exp=%h", i, out, 16'h0000);
      end
    end
  endtask
  task automatic test_select_sweep();
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      select = 3'(s);
      step();
      checks++;
      if (out !== 16'(15 + s)) begin
        failures++;
        $display("FAIL sweep_sel%0d got=%h exp=%h", s, out, 16'(15 + s));
      end
    end
  endtask
  task automatic test_hold();
    select = 3'd3;
    step();
    checks++;
    if (out !== 16'd18) begin
      failures++;
      $display("FAIL hold_initial got=%h exp=%h", out, 16'd18);
    end
    #2 din[3] = 16'hBEEF;
    din[2] = 16'h1234;
    #1;
    checks++;
    if (out !== 16'd18) begin
      failures++;
      $display("FAIL hold_between_edges got=%h exp=%h", out, 16'd18);
    end
    step();
    checks++;
    if (out !== 16'hBEEF) begin
      failures++;
      $display("FAIL hold_next_edge got=%h exp=%h", out, 16'hBEEF);
    end
    step();
    checks++;
    if (out !== 16'hBEEF) begin
      failures++;
      $display("FAIL hold_other_input got=%h exp=%h", out, 16'hBEEF);
    end
  endtask
  task automatic test_full_width();
    din[7] = 16'hFFFF;
    din[0] = 16'h8001;
    for (int i = 0; i < 6; i++) begin
      select = (i % 2 == 0) ? 3'd7 : 3'd0;
      step();
      checks++;
      if (out !== ((i % 2 == 0) ? 16'hFFFF : 16'h8001)) begin
        failures++;
        $display("FAIL full_width_%0d got=%h exp=%h", i, out, (i % 2 == 0) ? 16'hFFFF : 16'h8001);
      end
    end
  endtask
  task automatic test_mid_reset();
    load_base();
    select = 3'd6;
    step();
    checks++;
    if (out !== 16'd21) begin
      failures++;
      $display("FAIL mid_reset_pre got=%h exp=%h", out, 16'd21);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (out !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset_assert got=%h exp=%h", out, 16'h0000);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (out !== 16'd21) begin
      failures++;
      $display("FAIL mid_reset_release got=%h exp=%h", out, 16'd21);
    end
  endtask
  task automatic test_random();
    logic [15:0] exp;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 8; i++) din[i] = 16'($urandom);
      select = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 7) != 0);
      exp = rst_n ? din[select] : 16'h0000;
      step();
      checks++;
      if (out !== exp) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h exp=%h", c, out, exp);
      end
    end
  endtask
  initial begin
    load_base();
    test_reset();
    test_select_sweep();
    test_hold();
    test_full_width();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
